incr_decr_ctrl: RTL
===================

// Module: incr_decr_ctrl
// PURPOSE
// - Round-robin arbiter and sequencer sharing one incr_decr datapath among NREQ requesters.
// - Runs the full incr_decr op handshake (val_op/op_ack/op_commit) and returns the result
//   to the granted requester.
// - Optional: dumps the datapath scan chain non-destructively after each committed op.
// PARAMETERS
// - NREQ      2    number of requesters (>=2)
// - DW        8    data width of incr_decr operand/result
// - TIMEOUT   200  max cycles waited for op_ack or op_commit before abort
// - CHAIN_LEN 16   scan-chain length of the incr_decr instance (bits)
// PORTS
// - clk            in   1          system clock, rising edge
// - reset          in   1          asynchronous, active-high
// - req_val        in   NREQ       requester i has an op pending
// - req_rdy        out  NREQ       one-hot; op of requester i accepted this cycle
// - req_data       in   NREQ*DW    operand, requester i at [i*DW +: DW]
// - req_op         in   NREQ       1 = increment (add), 0 = decrement (sub)
// - resp_val       out  NREQ       one-hot; result valid for requester i
// - resp_rdy       in   NREQ       requester i consumes result
// - resp_data      out  DW         result (0 on error)
// - resp_err       out  1          qualifies resp_val; 1 = op timed out
// - dut_data_in    out  DW         to incr_decr data_in
// - dut_a_s        out  1          to incr_decr a_s
// - dut_val_op     out  1          to incr_decr val_op
// - dut_data_out   in   DW         from incr_decr data_out
// - dut_op_ack     in   1          from incr_decr op_ack
// - dut_op_commit  in   1          from incr_decr op_commit
// - dut_sen        out  1          to incr_decr sen
// - dut_scan_ce    out  1          to incr_decr scan_ce
// - dut_sin        out  1          to incr_decr sin
// - dut_sout       in   1          from incr_decr sout
// - snap_data      out  CHAIN_LEN  last scan snapshot
// - snap_val       out  1          1-cycle pulse when snap_data is updated
// BEHAVIOUR
// - Reset: every output 0, FSM=IDLE, RR pointer=0, timer=0; dut_val_op drops immediately.
// - FSM: IDLE -> ISSUE -> WAIT_COMMIT -> [SCAN] -> RESP -> IDLE.
// - IDLE: grant the first req_val at/after the RR pointer; req_rdy[g]=1 for that cycle.
//   Latch data/op/g; pointer <= (g+1) mod NREQ. No req_val: stay in IDLE.
// - ISSUE (entered the cycle after grant): dut_val_op=1, dut_data_in/dut_a_s=latched.
//   - op_ack sampled high -> val_op 0 next cycle, go to WAIT_COMMIT.
// - WAIT_COMMIT: on op_commit, capture dut_data_out into resp_data.
//   - Next state is SCAN if SCAN_DUMP_EN is defined, else RESP.
// - Timer: cleared on entry to ISSUE/WAIT_COMMIT.
//   - Reaching TIMEOUT -> val_op=0, resp_err=1, resp_data=0, go to RESP (no SCAN).
// - RESP: resp_val[g]=1 with data/err held until resp_rdy[g]; then IDLE.
//   - Earliest next grant: the cycle after the resp handshake.
// - resp_rdy of non-granted requesters is ignored. req_val may drop while not granted.
// - dut_sen, dut_scan_ce and dut_sin are 0 outside SCAN.
// CONFIGURATION
// - SCAN_DUMP_EN defined: SCAN state drives dut_sen=dut_scan_ce=1 for exactly CHAIN_LEN
//   cycles, with dut_sin=dut_sout (circular, so DUT state is preserved).
//   - snap_data shifts left, dut_sout entering bit 0; the first bit out ends at the MSB.
//   - snap_val pulses on the last shift cycle, then go to RESP.
// - SCAN_DUMP_EN undefined: no SCAN state. dut_sen/dut_scan_ce/dut_sin/snap_data/snap_val
//   are tied to 0.
// STRUCTURE
// - incr_decr_pkg holds: FSM state encodings, OP_ADD=1'b1, OP_SUB=1'b0, default DW.
// - Sub-module rr_arbiter (NREQ): req vector + pointer -> one-hot grant, pointer update.
// TESTING
// - req0 sends 0x41 with op=add -> dut_a_s=1, dut_val_op held until ack;
//   resp_val[0] with resp_data=0x42, resp_err=0.
// - req0 and req1 both valid from reset -> grant order 0,1,0,1 over 4 ops;
//   a single req_rdy is high per grant.
// - req1 sends 0x00 with op=sub -> resp_data=0xFF. req0 sends 0xFF with op=add -> 0x00.
// - DUT model never asserts op_ack -> resp_err=1, resp_data=0 after 200 cycles;
//   dut_val_op=0; the next request succeeds.
// - Assert reset in WAIT_COMMIT -> all outputs 0 at once. After release a fresh req0
//   gets the grant and completes.
// - SCAN_DUMP_EN: after commit, dut_sen=dut_scan_ce=1 for exactly 16 cycles.
//   snap_data matches the model chain; a second dump gives an identical snapshot.

Source files
------------

// File: rtl/incr_decr_pkg.sv
// Shared types and constants for the incr_decr controller slice.
package incr_decr_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_COMMIT = 3'd2,
    ST_SCAN        = 3'd3,
    ST_RESP        = 3'd4
  } state_t;

  // Index width for an n-entry vector; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/incr_decr_ctrl_if.sv
// Requester-side request/response bus of the incr_decr controller.
interface incr_decr_ctrl_if
  import incr_decr_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = DW_DEFAULT
);
  logic [NREQ-1:0]    req_val;
  logic [NREQ-1:0]    req_rdy;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_op;
  logic [NREQ-1:0]    resp_val;
  logic [NREQ-1:0]    resp_rdy;
  logic [DW-1:0]      resp_data;
  logic               resp_err;

  modport master (
    output req_val, req_data, req_op, resp_rdy,
    input  req_rdy, resp_val, resp_data, resp_err
  );

  modport slave (
    input  req_val, req_data, req_op, resp_rdy,
    output req_rdy, resp_val, resp_data, resp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at/after ptr wins; next_ptr follows the winner.
module rr_arbiter
  import incr_decr_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any,
  output logic [PW-1:0]   next_ptr
);
  logic [PW-1:0] cand;
  logic [PW-1:0] win;

  always_comb begin
    gnt  = '0;
    any  = 1'b0;
    win  = '0;
    cand = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (32'(ptr) + off >= NREQ) ? PW'(32'(ptr) + off - NREQ) : PW'(32'(ptr) + off);
      if (!any && req[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
    if (any) gnt[win] = 1'b1;
    next_ptr = (32'(win) + 32'd1 >= NREQ) ? '0 : PW'(32'(win) + 32'd1);
  end

endmodule

// File: rtl/incr_decr_ctrl.sv
// Arbitrates NREQ requesters onto one incr_decr datapath and sequences its op handshake.
// Define SCAN_DUMP_EN to add a non-destructive scan-chain snapshot after each committed op.
module incr_decr_ctrl
  import incr_decr_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned DW        = DW_DEFAULT,
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned CHAIN_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  incr_decr_ctrl_if.slave      req_if,
  output logic [DW-1:0]        dut_data_in,
  output logic                 dut_a_s,
  output logic                 dut_val_op,
  input  logic [DW-1:0]        dut_data_out,
  input  logic                 dut_op_ack,
  input  logic                 dut_op_commit,
  output logic                 dut_sen,
  output logic                 dut_scan_ce,
  output logic                 dut_sin,
  input  logic                 dut_sout,
  output logic [CHAIN_LEN-1:0] snap_data,
  output logic                 snap_val
);
  localparam int unsigned PW = idx_w(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   data_in_q, data_in_d;
  logic            a_s_q, a_s_d;
  logic            val_op_q, val_op_d;
  logic [NREQ-1:0] resp_val_q, resp_val_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic [NREQ-1:0] arb_gnt;
  logic            arb_any;
  logic [PW-1:0]   arb_next_ptr;
  logic [DW-1:0]   sel_data;
  logic            sel_op;
  logic            timed_out;

`ifdef SCAN_DUMP_EN
  localparam int unsigned CW = idx_w(CHAIN_LEN);
  logic                 sen_q, sen_d;
  logic [CW-1:0]        scnt_q, scnt_d;
  logic [CHAIN_LEN-1:0] snap_q, snap_d;
  logic                 snap_val_q, snap_val_d;
`endif

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req      (req_if.req_val),
    .ptr      (ptr_q),
    .gnt      (arb_gnt),
    .any      (arb_any),
    .next_ptr (arb_next_ptr)
  );

  // Operand/op of the requester being granted this cycle.
  always_comb begin
    sel_data = '0;
    sel_op   = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (arb_gnt[i]) begin
        sel_data = req_if.req_data[i*DW +: DW];
        sel_op   = req_if.req_op[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    timer_d     = timer_q;
    data_in_d   = data_in_q;
    a_s_d       = a_s_q;
    val_op_d    = val_op_q;
    resp_val_d  = resp_val_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    timed_out   = (timer_q == TW'(TIMEOUT - 1));
`ifdef SCAN_DUMP_EN
    sen_d      = sen_q;
    scnt_d     = scnt_q;
    snap_d     = snap_q;
    snap_val_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d   = ST_ISSUE;
          ptr_d     = arb_next_ptr;
          gnt_d     = arb_gnt;
          data_in_d = sel_data;
          a_s_d     = sel_op;
          val_op_d  = 1'b1;
          timer_d   = '0;
        end
      end

      ST_ISSUE, ST_WAIT_COMMIT: begin
        if (state_q == ST_ISSUE && dut_op_ack) begin
          val_op_d = 1'b0;
          state_d  = ST_WAIT_COMMIT;
          timer_d  = '0;
        end else if (state_q == ST_WAIT_COMMIT && dut_op_commit) begin
          resp_data_d = dut_data_out;
          resp_err_d  = 1'b0;
`ifdef SCAN_DUMP_EN
          state_d = ST_SCAN;
          sen_d   = 1'b1;
          scnt_d  = '0;
`else
          state_d    = ST_RESP;
          resp_val_d = gnt_q;
`endif
        end else if (timed_out) begin
          // Abort: no scan dump, report an error result.
          val_op_d    = 1'b0;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
          resp_val_d  = gnt_q;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

`ifdef SCAN_DUMP_EN
      // Circular shift: sout is fed back into sin so the chain contents survive.
      ST_SCAN: begin
        snap_d = {snap_q[CHAIN_LEN-2:0], dut_sout};
        if (scnt_q == CW'(CHAIN_LEN - 1)) begin
          sen_d      = 1'b0;
          snap_val_d = 1'b1;
          resp_val_d = gnt_q;
          state_d    = ST_RESP;
        end else begin
          scnt_d = scnt_q + CW'(1);
        end
      end
`endif

      ST_RESP: begin
        if (|(req_if.resp_rdy & gnt_q)) begin
          resp_val_d = '0;
          resp_err_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      timer_q     <= '0;
      data_in_q   <= '0;
      a_s_q       <= 1'b0;
      val_op_q    <= 1'b0;
      resp_val_q  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
`ifdef SCAN_DUMP_EN
      sen_q      <= 1'b0;
      scnt_q     <= '0;
      snap_q     <= '0;
      snap_val_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      timer_q     <= timer_d;
      data_in_q   <= data_in_d;
      a_s_q       <= a_s_d;
      val_op_q    <= val_op_d;
      resp_val_q  <= resp_val_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
`ifdef SCAN_DUMP_EN
      sen_q      <= sen_d;
      scnt_q     <= scnt_d;
      snap_q     <= snap_d;
      snap_val_q <= snap_val_d;
`endif
    end
  end

  assign req_if.req_rdy   = (state_q == ST_IDLE) ? arb_gnt : '0;
  assign req_if.resp_val  = resp_val_q;
  assign req_if.resp_data = resp_data_q;
  assign req_if.resp_err  = resp_err_q;
  assign dut_data_in      = data_in_q;
  assign dut_a_s          = a_s_q;
  assign dut_val_op       = val_op_q;

`ifdef SCAN_DUMP_EN
  assign dut_sen     = sen_q;
  assign dut_scan_ce = sen_q;
  assign dut_sin     = sen_q & dut_sout;
  assign snap_data   = snap_q;
  assign snap_val    = snap_val_q;
`else
  logic unused_sout;
  assign unused_sout = dut_sout;
  assign dut_sen     = 1'b0;
  assign dut_scan_ce = 1'b0;
  assign dut_sin     = 1'b0;
  assign snap_data   = '0;
  assign snap_val    = 1'b0;
`endif

endmodule
